insn_fetch: RTL and testbench
=============================

# insn_fetch

Instruction fetch unit. It sits directly upstream of the multicycle control FSM. It holds the program counter (PC) and the instruction register (IR), and runs a req/ack read handshake to instruction memory. It decodes IR into the OPCODE/MM/register/immediate fields that the controller and datapath consume. It executes the controller's PC commands: PC_WRITE, PC_SEL, BR_SEL, PC_RST.

## Interface
- PC_W, 16, PC and instruction-memory address width (word addressed)
- INSN_W, 32, instruction width; field layout below assumes 32

- CLK  in  1  single clock; all state updates on rising edge
- RST_F  in  1  reset, asynchronous, active-low
- PC_RST  in  1  synchronous PC/IR clear from controller, active-high
- PC_WRITE  in  1  PC command strobe, sampled each rising edge
- PC_SEL  in  1  0 = fetch (read mem[PC], then PC+1); 1 = branch load
- BR_SEL  in  1  branch kind when PC_SEL=1: 0 = relative, 1 = absolute
- IM_REQ  out  1  instruction memory read request (registered)
- IM_ADDR  out  PC_W  read address; equals PC while IM_REQ=1
- IM_RDATA  in  INSN_W  read data, valid when IM_ACK=1
- IM_ACK  in  1  read acknowledge, single-cycle pulse
- OPCODE  out  4  IR[31:28]
- MM  out  4  IR[27:24], addressing mode / branch condition mask
- RD  out  4  IR[23:20]
- RS  out  4  IR[19:16]
- IMM  out  16  IR[15:0]
- PC  out  PC_W  current program counter
- IR_VALID  out  1  IR holds a freshly fetched instruction
- FETCH_BUSY  out  1  read in flight; new commands not accepted
- HALTED  out  1  IR opcode is HLT (4'hF); fetch frozen
- PROTO_ERR  out  1  sticky: command received while busy or halted

## Operation
- States: IDLE, REQ.
- Reset (RST_F low) forces state IDLE. All outputs and registers go to 0: PC, IR, IM_REQ, IR_VALID, HALTED, PROTO_ERR. Decoded fields follow IR, so they also read 0.
- Command priority at each edge: PC_RST, then fetch/branch command, then IM_ACK.
- PC_RST=1:
  - PC, IR, IR_VALID and HALTED go to 0.
  - State goes to IDLE and IM_REQ drops.
  - PROTO_ERR is retained.
  - An outstanding read is abandoned. Its late IM_ACK is ignored because IM_ACK is ignored in IDLE.
- IDLE, PC_WRITE=1, PC_SEL=0, HALTED=0 (fetch):
  - State goes to REQ; IM_REQ goes to 1 and IM_ADDR to PC.
  - IR_VALID goes to 0.
- REQ:
  - IM_REQ and IM_ADDR are held stable until IM_ACK.
  - On an edge with IM_ACK=1: IR takes IM_RDATA, PC takes PC+1, IM_REQ goes to 0, IR_VALID goes to 1, state goes to IDLE.
  - HALTED is set if IM_RDATA[31:28]=4'hF.
- IDLE, PC_WRITE=1, PC_SEL=1, HALTED=0 (branch):
  - Relative (BR_SEL=0): PC takes PC + sign_extend(IMM). Arithmetic is modulo 2^PC_W. PC already points to the word after the branch instruction.
  - Absolute (BR_SEL=1): PC takes IMM, zero-extended, or truncated to its low PC_W bits.
  - IR_VALID goes to 0; state stays IDLE.
- A command while FETCH_BUSY=1 or HALTED=1 is ignored (no state, PC or IR change) and PROTO_ERR is set.
- PC_SEL and BR_SEL are don't-care when PC_WRITE=0.
- PC wrap: PC+1 from all-ones gives 0. Relative branches wrap the same way. Neither is an error.
- HALTED clears only on RST_F or PC_RST.

## Timing
- Decoded fields (OPCODE, MM, RD, RS, IMM) and PC are combinational from registers: glitch-free, valid right after the edge.
- FETCH_BUSY = (state==REQ), taken directly from the state register.
- Fetch latency: command sampled at edge n, IM_REQ high after edge n. The earliest accepted IM_ACK is at edge n+1, so IR/OPCODE are valid after edge n+1 (2 cycles minimum). Each memory wait cycle adds 1.
- An IM_ACK sampled at the same edge that IM_REQ first rises (edge n) is not a response and is ignored.
- Branch latency: new PC is visible after the sampling edge (1 cycle).
- Simultaneous PC_RST and IM_ACK in REQ: PC_RST wins and IR is not loaded.
- Controller rule: hold the next command until FETCH_BUSY=0.

## Test plan
- Reset/fetch: RST_F low then high. PC_WRITE=1, PC_SEL=0 for one cycle. Memory acks after 3 wait cycles with 32'h8412_0005. Required: IM_REQ high 4 cycles with IM_ADDR=0; then OPCODE=8, MM=4, RD=1, RS=2, IMM=5, PC=1, IR_VALID=1.
- Branches:
  - PC=16'h0010, IMM=16'hFFFC, relative branch: PC=16'h000C.
  - Absolute branch with IMM=16'h0123: PC=16'h0123.
  - PC=16'hFFFF with fetch: PC wraps to 0.
- Busy violation: fetch command issued, then PC_WRITE=1 during REQ before ack. Required: PC, IR and IM_ADDR unchanged; PROTO_ERR=1 and stays 1 after a later PC_RST.
- Abort: PC_RST asserted during REQ at the same edge as IM_ACK. Required: PC=0, IR=0, IM_REQ=0, IR_VALID=0, state IDLE. A later stray IM_ACK changes nothing.
- Halt: fetched word 32'hF000_0000. Required: HALTED=1. A subsequent fetch command is ignored (IM_REQ stays 0) and sets PROTO_ERR. PC_RST clears HALTED.
- Async reset mid-read: RST_F pulsed low between clock edges during REQ. Required: IM_REQ, PC, IR and all flags go to 0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/insn_fetch.sv
// rtl/insn_fetch.sv - instruction fetch unit: PC, IR, imem req/ack handshake, IR field decode
//
// Ports:
//   CLK, RST_F            clock, asynchronous active-low reset
//   PC_RST                synchronous PC/IR/HALTED clear (PROTO_ERR kept)
//   PC_WRITE, PC_SEL,     PC command strobe; PC_SEL 0 = fetch, 1 = branch;
//   BR_SEL                BR_SEL 0 = relative, 1 = absolute
//   IM_REQ, IM_ADDR       instruction memory read request / word address
//   IM_RDATA, IM_ACK      read data and single-cycle acknowledge
//   OPCODE, MM, RD, RS,   decoded fields of IR
//   IMM
//   PC                    program counter
//   IR_VALID              IR holds a freshly fetched instruction
//   FETCH_BUSY            read in flight
//   HALTED                IR opcode is HLT; fetch frozen
//   PROTO_ERR             sticky: command received while busy or halted
module insn_fetch #(
  parameter int PC_W   = 16,
  parameter int INSN_W = 32
) (
  input  logic              CLK,
  input  logic              RST_F,
  input  logic              PC_RST,
  input  logic              PC_WRITE,
  input  logic              PC_SEL,
  input  logic              BR_SEL,
  output logic              IM_REQ,
  output logic [PC_W-1:0]   IM_ADDR,
  input  logic [INSN_W-1:0] IM_RDATA,
  input  logic              IM_ACK,
  output logic [3:0]        OPCODE,
  output logic [3:0]        MM,
  output logic [3:0]        RD,
  output logic [3:0]        RS,
  output logic [15:0]       IMM,
  output logic [PC_W-1:0]   PC,
  output logic              IR_VALID,
  output logic              FETCH_BUSY,
  output logic              HALTED,
  output logic              PROTO_ERR
);

  localparam logic [3:0] OP_HLT = 4'hF;

  typedef enum logic [0:0] {IDLE, REQ} state_t;

  state_t              state, state_n;
  logic [PC_W-1:0]     pc, pc_n;
  logic [INSN_W-1:0]   ir, ir_n;
  logic                ir_valid, ir_valid_n;
  logic                halted, halted_n;
  logic                proto_err, proto_err_n;

  // IMM sign-extended (or truncated) to PC width for relative branches,
  // zero-extended (or truncated) for absolute ones.
  logic [PC_W-1:0]     br_rel_off;
  logic [PC_W-1:0]     br_abs_tgt;

  assign br_rel_off = PC_W'($signed(ir[15:0]));
  assign br_abs_tgt = PC_W'(ir[15:0]);

  always_ff @(posedge CLK or negedge RST_F) begin
    if (!RST_F) begin
      state     <= IDLE;
      pc        <= '0;
      ir        <= '0;
      ir_valid  <= 1'b0;
      halted    <= 1'b0;
      proto_err <= 1'b0;
    end else begin
      state     <= state_n;
      pc        <= pc_n;
      ir        <= ir_n;
      ir_valid  <= ir_valid_n;
      halted    <= halted_n;
      proto_err <= proto_err_n;
    end
  end

  always_comb begin
    state_n     = state;
    pc_n        = pc;
    ir_n        = ir;
    ir_valid_n  = ir_valid;
    halted_n    = halted;
    proto_err_n = proto_err;

    if (PC_RST) begin
      // Abandons any outstanding read; its late ack lands in IDLE and is ignored.
      state_n    = IDLE;
      pc_n       = '0;
      ir_n       = '0;
      ir_valid_n = 1'b0;
      halted_n   = 1'b0;
    end else begin
      if (PC_WRITE) begin
        if (state == REQ || halted) begin
          proto_err_n = 1'b1;
        end else if (!PC_SEL) begin
          state_n    = REQ;
          ir_valid_n = 1'b0;
        end else begin
          pc_n       = BR_SEL ? br_abs_tgt : pc + br_rel_off;
          ir_valid_n = 1'b0;
        end
      end
      // A rejected command must not swallow the ack, otherwise the read would
      // never complete. An ack on the edge that raises IM_REQ is seen in IDLE
      // and therefore ignored.
      if (state == REQ && IM_ACK) begin
        state_n    = IDLE;
        ir_n       = IM_RDATA;
        pc_n       = pc + PC_W'(1);
        ir_valid_n = 1'b1;
        if (IM_RDATA[INSN_W-1 -: 4] == OP_HLT) halted_n = 1'b1;
      end
    end
  end

  // PC only moves on ack, so it is stable for the whole request.
  assign IM_REQ     = (state == REQ);
  assign IM_ADDR    = pc;
  assign FETCH_BUSY = (state == REQ);
  assign PC         = pc;
  assign IR_VALID   = ir_valid;
  assign HALTED     = halted;
  assign PROTO_ERR  = proto_err;

  assign OPCODE = ir[31:28];
  assign MM     = ir[27:24];
  assign RD     = ir[23:20];
  assign RS     = ir[19:16];
  assign IMM    = ir[15:0];

endmodule

// File: tb/tb_insn_fetch.sv
// tb/tb_insn_fetch.sv - directed scoreboard bench for insn_fetch
module tb_insn_fetch;

  logic        CLK;
  logic        RST_F;
  logic        PC_RST;
  logic        PC_WRITE;
  logic        PC_SEL;
  logic        BR_SEL;
  logic        IM_REQ;
  logic [15:0] IM_ADDR;
  logic [31:0] IM_RDATA;
  logic        IM_ACK;
  logic [3:0]  OPCODE;
  logic [3:0]  MM;
  logic [3:0]  RD;
  logic [3:0]  RS;
  logic [15:0] IMM;
  logic [15:0] PC;
  logic        IR_VALID;
  logic        FETCH_BUSY;
  logic        HALTED;
  logic        PROTO_ERR;

  insn_fetch #(.PC_W(16), .INSN_W(32)) dut (
    .CLK(CLK), .RST_F(RST_F), .PC_RST(PC_RST), .PC_WRITE(PC_WRITE),
    .PC_SEL(PC_SEL), .BR_SEL(BR_SEL), .IM_REQ(IM_REQ), .IM_ADDR(IM_ADDR),
    .IM_RDATA(IM_RDATA), .IM_ACK(IM_ACK), .OPCODE(OPCODE), .MM(MM),
    .RD(RD), .RS(RS), .IMM(IMM), .PC(PC), .IR_VALID(IR_VALID),
    .FETCH_BUSY(FETCH_BUSY), .HALTED(HALTED), .PROTO_ERR(PROTO_ERR)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    logic [31:0] word;
    logic [15:0] pc;
  } exp_t;

  exp_t        exp_q[$];
  int          tests;
  int          failed;
  logic [15:0] pc_model;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_fetch(input logic [31:0] word, input int waits);
    exp_t e;
    exp_t got;
    e.word = word;
    e.pc   = pc_model + 16'd1;
    exp_q.push_back(e);
    PC_WRITE = 1'b1; PC_SEL = 1'b0;
    tick();
    PC_WRITE = 1'b0;
    check("fetch_ir_valid_clr", IR_VALID, 0);
    for (int i = 0; i < waits; i++) begin
      check("fetch_req_wait", IM_REQ, 1);
      check("fetch_addr_wait", IM_ADDR, pc_model);
      tick();
    end
    check("fetch_req_at_ack", IM_REQ, 1);
    check("fetch_addr_at_ack", IM_ADDR, pc_model);
    IM_ACK = 1'b1; IM_RDATA = word;
    tick();
    IM_ACK = 1'b0; IM_RDATA = '0;
    got = exp_q.pop_front();
    check("fetch_ir", {OPCODE, MM, RD, RS, IMM}, got.word);
    check("fetch_pc", PC, got.pc);
    check("fetch_ir_valid", IR_VALID, 1);
    check("fetch_req_done", IM_REQ, 0);
    check("fetch_halted", HALTED, got.word[31:28] == 4'hF);
    pc_model = got.pc;
  endtask

  task automatic do_branch(input logic abs_br, input logic [15:0] exp_pc);
    PC_WRITE = 1'b1; PC_SEL = 1'b1; BR_SEL = abs_br;
    tick();
    PC_WRITE = 1'b0; PC_SEL = 1'b0; BR_SEL = 1'b0;
    check("branch_pc", PC, exp_pc);
    check("branch_ir_valid", IR_VALID, 0);
    check("branch_no_req", IM_REQ, 0);
    pc_model = exp_pc;
  endtask

  initial begin
    exp_t e;
    exp_t got;
    tests = 0; failed = 0; pc_model = 16'h0000;
    RST_F = 1'b0; PC_RST = 1'b0; PC_WRITE = 1'b0; PC_SEL = 1'b0;
    BR_SEL = 1'b0; IM_ACK = 1'b0; IM_RDATA = '0;
    tick(); tick();

    check("rst_pc", PC, 0);
    check("rst_ir", {OPCODE, MM, RD, RS, IMM}, 0);
    check("rst_req", IM_REQ, 0);
    check("rst_ir_valid", IR_VALID, 0);
    check("rst_halted", HALTED, 0);
    check("rst_proto_err", PROTO_ERR, 0);
    check("rst_busy", FETCH_BUSY, 0);
    @(negedge CLK);
    RST_F = 1'b1;
    tick();

    // First fetch: 3 wait cycles, IM_REQ high 4 cycles at address 0.
    do_fetch(32'h8412_0005, 3);
    check("tp_opcode", OPCODE, 4'h8);
    check("tp_mm", MM, 4'h4);
    check("tp_rd", RD, 4'h1);
    check("tp_rs", RS, 4'h2);
    check("tp_imm", IMM, 16'h0005);
    check("tp_pc", PC, 16'h0001);

    // Branches.
    do_fetch(32'h1000_000F, 1);
    do_branch(1'b1, 16'h000F);
    do_fetch(32'h2000_FFFC, 0);
    check("rel_pre_pc", PC, 16'h0010);
    do_branch(1'b0, 16'h000C);
    do_fetch(32'h3000_0123, 2);
    do_branch(1'b1, 16'h0123);

    // PC wrap from all-ones.
    do_fetch(32'h3000_FFFF, 0);
    do_branch(1'b1, 16'hFFFF);
    do_fetch(32'h1000_0000, 0);
    check("wrap_pc", PC, 16'h0000);

    // Busy violation.
    PC_WRITE = 1'b1; PC_SEL = 1'b0;
    tick();
    PC_WRITE = 1'b0;
    tick();
    PC_WRITE = 1'b1; PC_SEL = 1'b1; BR_SEL = 1'b1;
    tick();
    PC_WRITE = 1'b0; PC_SEL = 1'b0; BR_SEL = 1'b0;
    check("busy_pc", PC, 16'h0000);
    check("busy_addr", IM_ADDR, 16'h0000);
    check("busy_ir", {OPCODE, MM, RD, RS, IMM}, 32'h1000_0000);
    check("busy_req", IM_REQ, 1);
    check("busy_proto_err", PROTO_ERR, 1);
    e.word = 32'h4567_89AB; e.pc = 16'h0001;
    exp_q.push_back(e);
    IM_ACK = 1'b1; IM_RDATA = 32'h4567_89AB;
    tick();
    IM_ACK = 1'b0; IM_RDATA = '0;
    got = exp_q.pop_front();
    check("busy_done_ir", {OPCODE, MM, RD, RS, IMM}, got.word);
    check("busy_done_pc", PC, got.pc);
    PC_RST = 1'b1;
    tick();
    PC_RST = 1'b0;
    check("pcrst_pc", PC, 16'h0000);
    check("pcrst_ir", {OPCODE, MM, RD, RS, IMM}, 0);
    check("pcrst_proto_err_kept", PROTO_ERR, 1);
    pc_model = 16'h0000;

    // Abort: PC_RST and IM_ACK on the same edge in REQ.
    do_fetch(32'h6000_0000, 0);
    PC_WRITE = 1'b1; PC_SEL = 1'b0;
    tick();
    PC_WRITE = 1'b0;
    tick();
    IM_ACK = 1'b1; IM_RDATA = 32'h7777_7777; PC_RST = 1'b1;
    tick();
    IM_ACK = 1'b0; IM_RDATA = '0; PC_RST = 1'b0;
    check("abort_pc", PC, 16'h0000);
    check("abort_ir", {OPCODE, MM, RD, RS, IMM}, 0);
    check("abort_req", IM_REQ, 0);
    check("abort_ir_valid", IR_VALID, 0);
    check("abort_busy", FETCH_BUSY, 0);
    IM_ACK = 1'b1; IM_RDATA = 32'h5555_5555;
    tick();
    IM_ACK = 1'b0; IM_RDATA = '0;
    check("stray_ack_ir", {OPCODE, MM, RD, RS, IMM}, 0);
    check("stray_ack_pc", PC, 16'h0000);
    check("stray_ack_ir_valid", IR_VALID, 0);
    pc_model = 16'h0000;

    // Async reset mid-read, between clock edges.
    do_fetch(32'h9ABC_DEF0, 0);
    PC_WRITE = 1'b1; PC_SEL = 1'b0;
    tick();
    PC_WRITE = 1'b0;
    check("async_pre_req", IM_REQ, 1);
    #2;
    RST_F = 1'b0;
    #1;
    check("async_req", IM_REQ, 0);
    check("async_pc", PC, 16'h0000);
    check("async_ir", {OPCODE, MM, RD, RS, IMM}, 0);
    check("async_ir_valid", IR_VALID, 0);
    check("async_proto_err", PROTO_ERR, 0);
    check("async_busy", FETCH_BUSY, 0);
    #1;
    RST_F = 1'b1;
    tick();
    pc_model = 16'h0000;

    // Halt.
    do_fetch(32'hF000_0000, 1);
    check("halt_set", HALTED, 1);
    check("halt_no_err_yet", PROTO_ERR, 0);
    PC_WRITE = 1'b1; PC_SEL = 1'b0;
    tick();
    PC_WRITE = 1'b0;
    check("halt_fetch_ignored", IM_REQ, 0);
    check("halt_proto_err", PROTO_ERR, 1);
    check("halt_pc_kept", PC, 16'h0001);
    PC_WRITE = 1'b1; PC_SEL = 1'b1; BR_SEL = 1'b0;
    tick();
    PC_WRITE = 1'b0; PC_SEL = 1'b0;
    check("halt_branch_ignored", PC, 16'h0001);
    check("halt_still", HALTED, 1);
    PC_RST = 1'b1;
    tick();
    PC_RST = 1'b0;
    check("halt_cleared", HALTED, 0);
    check("halt_err_kept", PROTO_ERR, 1);
    pc_model = 16'h0000;
    do_fetch(32'h0ABC_1234, 0);

    check("scoreboard_empty", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
